// File: rtl/piece_queue.sv
// piece_queue: fetches 7-piece bags from a bag generator and serves them in order
// as a FIFO of upcoming piece IDs with a 3-entry preview.
module piece_queue #(
    parameter int DEPTH   = 14,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    output logic        bag_newbag,
    input  logic        bag_ready,
    input  logic [20:0] bag_pieces,
    input  logic        piece_req,
    output logic        piece_valid,
    output logic [2:0]  piece_out,
    output logic [8:0]  preview,
    output logic [3:0]  count,
    output logic        bag_timeout,
    output logic        bag_err
);
    localparam int QW = 3 * DEPTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LOW = 4'(DEPTH - 7);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t        state_q;
    logic [QW-1:0] q_q, q_d, shifted, mask, ins;
    logic [3:0]    count_q, count_d, wr;
    logic [CW-1:0] cnt_q;
    logic          ready_prev_q, newbag_q, timeout_q, err_q;
    logic          edge_rise, pop, push, bad;
    logic [7:0]    seen;
    assign edge_rise = bag_ready && !ready_prev_q;
    assign pop       = piece_req && (count_q != 4'd0);
    assign push      = (state_q == WAIT) && edge_rise;
    assign wr        = count_q - {3'b000, pop};
    // Entry 0 is the head; a push lands right after the entries surviving a same-cycle pop.
    always_comb begin
        shifted = pop ? (q_q >> 3) : q_q;
        mask    = QW'(21'h1FFFFF) << (3 * wr);
        ins     = QW'(bag_pieces) << (3 * wr);
        q_d     = push ? ((shifted & ~mask) | ins) : shifted;
        count_d = wr + (push ? 4'd7 : 4'd0);
    end
    always_comb begin
        seen = '0;
        bad  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bad = bad | (bag_pieces[3*k +: 3] == 3'd7) | seen[bag_pieces[3*k +: 3]];
            seen[bag_pieces[3*k +: 3]] = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            newbag_q     <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
            ready_prev_q <= 1'b0;
            count_q      <= 4'd0;
            q_q          <= '0;
        end else begin
            ready_prev_q <= bag_ready;
            count_q      <= count_d;
            q_q          <= q_d;
            newbag_q     <= 1'b0;
            case (state_q)
                IDLE: if (count_q <= LOW) begin
                    state_q  <= REQ;
                    newbag_q <= 1'b1;
                end
                REQ: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: if (edge_rise) begin
                    state_q <= IDLE;
                    err_q   <= err_q | bad;
                end else if (cnt_q == TLAST) begin
                    state_q   <= REQ;
                    newbag_q  <= 1'b1;
                    timeout_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bag_newbag  = newbag_q;
    assign bag_timeout = timeout_q;
    assign bag_err     = err_q;
    assign count       = count_q;
    assign piece_valid = count_q != 4'd0;
    assign piece_out   = piece_valid ? q_q[2:0] : 3'b000;
    assign preview     = {count_q > 4'd3 ? q_q[11:9] : 3'b111,
                          count_q > 4'd2 ? q_q[8:6]  : 3'b111,
                          count_q > 4'd1 ? q_q[5:3]  : 3'b111};
endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter DEPTH, default 14, queue capacity in pieces; SHALL be at least 7.
REQ-002 Parameter TIMEOUT, default 1023, max cycles in WAIT before re-request.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bag_newbag  output  1  one-cycle pulse requesting a new 7-piece bag from the bag generator.
REQ-006 bag_ready  input  1  bag generator ready; its rising edge marks bag_pieces valid.
REQ-007 bag_pieces  input  21  seven 3-bit piece IDs; [2:0] is first in play order, [20:18] last.
REQ-008 piece_req  input  1  game logic consumes the head piece this cycle.
REQ-009 piece_valid  output  1  head piece present (count != 0).
REQ-010 piece_out  output  3  head piece ID.
REQ-011 preview  output  9  queue entries 1..3; [2:0] = entry 1; entries at or beyond count read 3'b111.
REQ-012 count  output  4  pieces currently queued, 0..DEPTH.
REQ-013 bag_timeout  output  1  sticky; a WAIT timeout has occurred.
REQ-014 bag_err  output  1  sticky; a received bag was not a permutation of 0..6.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT.
REQ-016 IDLE -> REQ when count <= DEPTH-7, evaluated on the registered count; otherwise remain in IDLE.
REQ-017 In REQ, bag_newbag SHALL be 1 for exactly that cycle; REQ -> WAIT unconditionally.
REQ-018 bag_newbag SHALL be 0 in every state other than REQ.
REQ-019 Rising edge = bag_ready==1 while the registered previous bag_ready==0; ready_prev SHALL update every cycle in every state.
REQ-020 A rising edge SHALL be accepted only in WAIT; edges in IDLE or REQ SHALL be ignored.
REQ-021 On accepted edge: push all 7 pieces at that clock edge in order [2:0] first through [20:18] last, then WAIT -> IDLE.
REQ-022 WAIT counter SHALL clear on entry to WAIT; if it reaches TIMEOUT with no edge, set bag_timeout, push nothing, WAIT -> REQ.
REQ-023 On accepted bag, if any ID is 7 or any ID repeats, set bag_err; the bag SHALL still be pushed unchanged.
REQ-024 Pop occurs when piece_req && piece_valid; the queue advances one entry and the new head appears on piece_out the next cycle.
REQ-025 piece_req with count==0 SHALL be ignored, with no state change.
REQ-026 Simultaneous pop and push in one cycle: next count = count - 1 + 7; the popped piece is the old head and the pushed pieces follow all surviving entries.
REQ-027 Overflow is impossible by REQ-016; count SHALL never exceed DEPTH.
REQ-028 piece_out SHALL be 3'b000 when count==0.
REQ-029 All outputs SHALL be driven from registers or from state decode only, never combinationally from inputs.

Reset
REQ-030 When reset is high at a rising clk edge: state=IDLE, count=0, queue contents=0, ready_prev=0, WAIT counter=0, bag_timeout=0, bag_err=0.
REQ-031 Reset SHALL take priority over pop, push, and all FSM transitions, including mid-WAIT.
REQ-032 After reset: first cycle IDLE, second cycle REQ (bag_newbag=1), third cycle WAIT.
REQ-033 A bag_ready edge arriving in the IDLE/REQ cycles after reset SHALL be ignored per REQ-020.

Verification
REQ-034 Reset, then bag model raises ready 5 cycles after each newbag with pieces [2:0..20:18]={3,0,6,1,5,2,4} -> bag_newbag pulses exactly 1 cycle in the second cycle after reset; after the first load count=7, piece_out=3, preview={0,6,1}; a second request follows and count reaches 14; no third request is issued.
REQ-035 count=7 with an edge accepted in the same cycle as piece_req=1 -> next count=13, piece_out=0, followed by the remaining first-bag entries then the new 7.
REQ-036 count=0, piece_req=1 held for 3 cycles -> count stays 0, piece_valid=0, piece_out=0, preview=9'h1FF.
REQ-037 Bag model never raises ready, TIMEOUT=15 -> bag_timeout=1 after 15 WAIT cycles, bag_newbag re-pulses the next cycle, count stays 0.
REQ-038 Bag {2,2,0,1,3,4,5} -> bag_err=1 and stays 1; count=7; piece_out=2.
REQ-039 Reset asserted mid-WAIT, then ready rises in the first cycle after reset -> no push, count=0, bag_err=0, bag_timeout=0; a fresh bag_newbag pulse occurs in the second cycle after reset.
